// File: rtl/mem_step_ctrl_pkg.sv
// mem_step_ctrl_pkg
//   Shared definitions for the memory step controller:
//   - mode_e        : controller mode encoding, also driven on the mode port
//   - TICK_DIV_DEFAULT : clk cycles per button-sample tick (500 Hz at 50 MHz)
//   - cnt_width()   : counter width helper that never returns zero
package mem_step_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_DUMP = 2'b10
  } mode_e;

  localparam int unsigned TICK_DIV_DEFAULT = 100000;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_step_ctrl_btn_pulse.sv
// btn_pulse
//   Samples a raw push-button on each tick through a two-flop synchroniser
//   and emits a one-clk pulse on every sampled rising edge.
//   Ports:
//     clk      in   system clock
//     rst_n    in   asynchronous active-low reset
//     tick_i   in   sample strobe
//     btn_i    in   raw button level
//     pulse_o  out  one-clk pulse per press
module btn_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q, hist_q;
  logic vld1_q, vld2_q;
  logic armed_q;
  logic pulse_q;

  // The zeroed synchroniser after reset would look like a release, so a
  // button held through reset would fire. armed_q only sets once a genuine
  // sample (vld2_q) has seen the button low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (tick_i) begin
        sync1_q <= btn_i;
        sync2_q <= sync1_q;
        hist_q  <= sync2_q;
        vld1_q  <= 1'b1;
        vld2_q  <= vld1_q;
        if (vld2_q && !sync2_q) armed_q <= 1'b1;
        pulse_q <= armed_q && sync2_q && !hist_q;
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/mem_step_ctrl.sv
// mem_step_ctrl
//   Front-panel controller for single-stepping a CPU and stepping through
//   memory. Modes: IDLE (one CPU clock-enable per step_clk press), RUN
//   (free-running enable every RUN_DIV clks), DUMP (CPU frozen, memory
//   address taken from an internal pointer stepped by step_mem presses).
//   Optional feature: define AUTO_DUMP_EN to also advance the dump pointer
//   every 256 ticks while in DUMP.
//   Ports:
//     clk, reset                    clock, async active-low reset
//     step_clk_btn, step_mem_btn    raw push-buttons
//     dump_mem, run                 level mode selects (dump_mem wins)
//     cpu_addr, cpu_we              CPU memory request
//     mem_dout                      RAM read data
//     cpu_clk_en                    one-clk CPU advance strobe
//     mem_addr, mem_we              RAM request
//     disp_data                     {mem_addr, mem_dout}
//     mode                          current mode encoding
//
//   state | meaning
//   IDLE  | CPU advances one clk per step_clk press
//   RUN   | CPU advances one clk every RUN_DIV clks
//   DUMP  | CPU frozen, RAM addressed by dump pointer
module mem_step_ctrl
  import mem_step_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       TICK_DIV = TICK_DIV_DEFAULT,
  parameter int unsigned       RUN_DIV  = 4,
  parameter logic [ADDR_W-1:0] DUMP_LO  = '0,
  parameter logic [ADDR_W-1:0] DUMP_HI  = '1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     step_clk_btn,
  input  logic                     step_mem_btn,
  input  logic                     dump_mem,
  input  logic                     run,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic                     cpu_we,
  input  logic [DATA_W-1:0]        mem_dout,
  output logic                     cpu_clk_en,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_we,
  output logic [ADDR_W+DATA_W-1:0] disp_data,
  output logic [1:0]               mode
);

  localparam int unsigned       TICK_W      = cnt_width(TICK_DIV);
  localparam int unsigned       RUN_W       = cnt_width(RUN_DIV);
  localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICK_DIV - 1);
  localparam logic [RUN_W-1:0]  RUN_RELOAD  = RUN_W'(RUN_DIV - 1);

  logic [TICK_W-1:0] tick_cnt_q;
  logic              tick;

  assign tick = (tick_cnt_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tick_cnt_q <= '0;
    else        tick_cnt_q <= tick ? TICK_RELOAD : tick_cnt_q - TICK_W'(1);
  end

  logic step_clk_pulse, step_mem_pulse;

  btn_pulse u_step_clk (
    .clk     (clk),
    .rst_n   (reset),
    .tick_i  (tick),
    .btn_i   (step_clk_btn),
    .pulse_o (step_clk_pulse)
  );

  btn_pulse u_step_mem (
    .clk     (clk),
    .rst_n   (reset),
    .tick_i  (tick),
    .btn_i   (step_mem_btn),
    .pulse_o (step_mem_pulse)
  );

  mode_e            state_q, state_d;
  logic [RUN_W-1:0] run_cnt_q;
  logic             cpu_clk_en_q;

  always_comb begin
    state_d = MODE_IDLE;
    if (dump_mem)  state_d = MODE_DUMP;
    else if (run)  state_d = MODE_RUN;
  end

  // Enable is decided from the next state so it never leaks into the first
  // DUMP cycle and RUN's first enable lines up with the mode change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= MODE_IDLE;
      run_cnt_q    <= '0;
      cpu_clk_en_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_cnt_q    <= '0;
      cpu_clk_en_q <= 1'b0;
      case (state_d)
        MODE_IDLE: cpu_clk_en_q <= step_clk_pulse;
        MODE_RUN: begin
          cpu_clk_en_q <= (run_cnt_q == '0);
          run_cnt_q    <= (run_cnt_q == '0) ? RUN_RELOAD : run_cnt_q - RUN_W'(1);
        end
        default: ;
      endcase
    end
  end

  logic [ADDR_W-1:0] dump_ptr_q;
  logic              dump_adv;

`ifdef AUTO_DUMP_EN
  logic [7:0] auto_tick_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    auto_tick_q <= '0;
    else if (tick) auto_tick_q <= auto_tick_q + 8'd1;
  end

  // A manual and an automatic step landing on the same clk advance once.
  assign dump_adv = step_mem_pulse || (tick && (auto_tick_q == 8'hFF));
`else
  assign dump_adv = step_mem_pulse;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dump_ptr_q <= DUMP_LO;
    end else if ((state_q == MODE_DUMP) && dump_adv) begin
      dump_ptr_q <= (dump_ptr_q == DUMP_HI) ? DUMP_LO : dump_ptr_q + ADDR_W'(1);
    end
  end

  assign cpu_clk_en = cpu_clk_en_q;
  assign mem_addr   = (state_q == MODE_DUMP) ? dump_ptr_q : cpu_addr;
  assign mem_we     = cpu_we && cpu_clk_en_q && (state_q != MODE_DUMP);
  assign disp_data  = {mem_addr, mem_dout};
  assign mode       = state_q;

endmodule

// File: doc/mem_step_ctrl.md
MEM_STEP_CTRL -- requirements
Module: mem_step_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory data width.
REQ-003 SHALL have parameter TICK_DIV, default 100000, clk cycles per button-sample tick (500 Hz at 50 MHz).
REQ-004 SHALL have parameter RUN_DIV, default 4, clk cycles per CPU clock-enable in RUN mode.
REQ-005 SHALL have parameters DUMP_LO / DUMP_HI, defaults 0 / 2**ADDR_W-1, inclusive dump address window.
REQ-006 SHALL have ports clk (input, 1, system clock) and reset (input, 1, asynchronous active-low reset), listed first.
REQ-007 SHALL have ports step_clk_btn and step_mem_btn (input, 1 each, raw push-buttons).
REQ-008 SHALL have ports dump_mem and run (input, 1 each, level mode selects).
REQ-009 SHALL have ports cpu_addr (input, ADDR_W) and cpu_we (input, 1), the CPU memory request.
REQ-010 SHALL have port mem_dout (input, DATA_W), RAM read data.
REQ-011 SHALL have port cpu_clk_en (output, 1), one-clk CPU advance strobe.
REQ-012 SHALL have ports mem_addr (output, ADDR_W) and mem_we (output, 1), the RAM request.
REQ-013 SHALL have port disp_data (output, ADDR_W+DATA_W), display word.
REQ-014 SHALL have port mode (output, 2), current state encoding.

Function
REQ-015 SHALL generate a tick pulse for one clk every TICK_DIV clk cycles from a free-running counter.
REQ-016 SHALL sample each button on tick through a 2-flop synchroniser and emit a one-clk pulse on each sampled 0->1 edge; holding a button SHALL yield exactly one pulse.
REQ-017 SHALL implement states IDLE=2'b00, RUN=2'b01, DUMP=2'b10, driven on mode.
REQ-018 SHALL select next state each clk: dump_mem=1 -> DUMP (highest priority), else run=1 -> RUN, else IDLE; change visible one clk after the input change.
REQ-019 In IDLE, cpu_clk_en SHALL equal the step_clk pulse (one clk per press).
REQ-020 In RUN, cpu_clk_en SHALL be 1 for one clk every RUN_DIV clk cycles; step_clk pulses ignored.
REQ-021 In DUMP, cpu_clk_en SHALL be 0 (CPU frozen).
REQ-022 mem_addr SHALL equal dump_ptr in DUMP, else cpu_addr (combinational).
REQ-023 mem_we SHALL equal cpu_we AND cpu_clk_en, forced 0 in DUMP.
REQ-024 dump_ptr SHALL advance by 1 on a step_mem pulse in DUMP only; from DUMP_HI it SHALL wrap to DUMP_LO.
REQ-025 step_mem pulses outside DUMP SHALL be ignored; dump_ptr SHALL be retained across mode exits and re-entries.
REQ-026 Simultaneous step_clk and step_mem pulses SHALL each act only in their own mode, independently.
REQ-027 disp_data SHALL equal {mem_addr, mem_dout} (combinational).

Reset
REQ-028 While reset=0: state IDLE, dump_ptr=DUMP_LO, tick and run counters 0, synchronisers 0, cpu_clk_en=0, mem_we=0.
REQ-029 A button held through reset release SHALL NOT produce a pulse until released and pressed again.
REQ-030 Reset asserted mid-RUN SHALL drop cpu_clk_en to 0 immediately (asynchronous).

Configuration
REQ-031 With AUTO_DUMP_EN defined, in DUMP dump_ptr SHALL additionally advance (same wrap rule) every 256 ticks; manual step_mem still advances it; on same clk both count once.
REQ-032 Without AUTO_DUMP_EN, dump_ptr SHALL advance only on step_mem pulses.

Structure
REQ-033 Shared package SHALL hold the mode encodings (IDLE/RUN/DUMP) and the default TICK_DIV constant.
REQ-034 The synchroniser + edge detector SHALL be one sub-module, btn_pulse, instantiated per button.

Verification (TICK_DIV=4, RUN_DIV=4, DUMP_LO=0, DUMP_HI=3)
REQ-035 Hold step_clk_btn 40 clk in IDLE -> exactly one cpu_clk_en pulse; cpu_we=1 -> mem_we one clk.
REQ-036 run=1 for 40 clk -> mode=01 after 1 clk, cpu_clk_en high every 4th clk (10 pulses), step_clk ignored.
REQ-037 dump_mem=1, 5 step_mem presses -> mem_addr 0,1,2,3,0,1; mem_we=0, cpu_clk_en=0 throughout; disp_data[31:16]=mem_addr.
REQ-038 run=1 and dump_mem=1 together -> mode=10; drop dump_mem -> mode=01, mem_addr=cpu_addr; re-enter DUMP -> dump_ptr retained.
REQ-039 reset=0 mid-RUN with dump_ptr=2 -> cpu_clk_en=0 at once, mode=00, dump_ptr=0; held button at release -> no pulse.
